// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked signed ALU. ADD/SUB/NOT/SLT/SGT and illegal opcodes
// complete in one cycle; MUL runs an iterative shift-add over WIDTH cycles.
// Optional build macro: SATURATE_EN (clamp ADD/SUB/MUL results on overflow).
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid/in_ready           operation handshake; in_ready high only in IDLE
//   in0, in1, funct             signed operands and opcode (0 ADD,1 SUB,2 MUL,
//                               3 NOT,4 SLT,5 SGT, 6-15 illegal)
//   out_valid/out_ready         result handshake
//   out, overflow, illegal      registered result and status
//   gr_flag, le_flag, eq_flag   signed compare of operands, captured at accept
module multicycle_alu #(
  parameter int WIDTH      = 11,
  parameter int TRUE_VALUE = 127
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in0,
  input  logic signed [WIDTH-1:0] in1,
  input  logic [3:0]              funct,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out,
  output logic                    overflow,
  output logic                    illegal,
  output logic                    gr_flag,
  output logic                    le_flag,
  output logic                    eq_flag
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] TRUE_W  = WIDTH'(TRUE_VALUE);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic            mul_neg;
  logic [PW-1:0]   acc;

  // Magnitude as an unsigned WIDTH-bit value; the most-negative input maps to 2^(W-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // Single-cycle operations, evaluated on the operands being accepted.
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = in0 + in1;
    diff    = in0 - in1;
    case (funct)
      4'd0: begin
        alu_res = sum;
        alu_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ovf = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in0[WIDTH-1]);
      end
      4'd3:    alu_res = (in0 == '0) ? TRUE_W : '0;
      4'd4:    alu_res = (in0 < in1) ? TRUE_W : '0;
      4'd5:    alu_res = (in0 > in1) ? TRUE_W : '0;
      default: alu_res = '0;
    endcase
`ifdef SATURATE_EN
    // On ADD/SUB overflow the true result carries the sign of in0.
    if (alu_ovf) alu_res = in0[WIDTH-1] ? MIN_VAL : MAX_VAL;
`endif
  end

  // Multiplier datapath: next accumulator value, signed product and final result.
  logic [PW-1:0]    pp, acc_nx, prod;
  logic [WIDTH:0]   prod_hi;
  logic             mul_ovf;
  logic [WIDTH-1:0] mul_res;

  always_comb begin
    pp      = b_mag[cnt] ? ({{WIDTH{1'b0}}, a_mag} << cnt) : '0;
    acc_nx  = acc + pp;
    prod    = mul_neg ? (~acc_nx + PW'(1)) : acc_nx;
    prod_hi = prod[PW-1:WIDTH-1];
    mul_ovf = !((&prod_hi) || !(|prod_hi));
    mul_res = prod[WIDTH-1:0];
`ifdef SATURATE_EN
    if (mul_ovf) mul_res = mul_neg ? MIN_VAL : MAX_VAL;
`endif
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      gr_flag   <= 1'b0;
      le_flag   <= 1'b0;
      eq_flag   <= 1'b0;
      cnt       <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      mul_neg   <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            gr_flag  <= in0 > in1;
            le_flag  <= in0 < in1;
            eq_flag  <= in0 == in1;
            illegal  <= funct > 4'd5;
            if (funct == 4'd2) begin
              a_mag   <= mag(in0);
              b_mag   <= mag(in1);
              mul_neg <= in0[WIDTH-1] ^ in1[WIDTH-1];
              acc     <= '0;
              cnt     <= '0;
              state   <= MUL_BUSY;
            end else begin
              out       <= alu_res;
              overflow  <= alu_ovf;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL_BUSY: begin
          // One partial product per cycle; the last one feeds the result directly.
          acc <= acc_nx;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt       <= '0;
            out       <= mul_res;
            overflow  <= mul_ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: self-checking bench for multicycle_alu (WIDTH=11, TRUE_VALUE=127).
// Directed vector table, backpressure and reset-abort sequences, then random
// operations checked against an integer-arithmetic reference model.
module tb_multicycle_alu;

  localparam int W  = 11;
  localparam int TV = 127;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0] in0, in1, out;
  logic [3:0] funct;
  logic overflow, illegal, gr_flag, le_flag, eq_flag;

  int n_cmp = 0;
  int n_fail = 0;

  multicycle_alu #(.WIDTH(W), .TRUE_VALUE(TV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .funct(funct), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .overflow(overflow), .illegal(illegal),
    .gr_flag(gr_flag), .le_flag(le_flag), .eq_flag(eq_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint m;
    m = v & ((longint'(1) <<< W) - 1);
    if (m > MAXV) m = m - (longint'(1) <<< W);
    return m;
  endfunction

  // Reference model: exact integer result, then range check, then wrap/clamp.
  task automatic model(input longint a, input longint b, input int f,
                       output longint o, output bit ov, output bit ill);
    longint t;
    ov = 1'b0; ill = 1'b0; o = 0; t = 0;
    case (f)
      0, 1, 2: begin
        t  = (f == 0) ? a + b : (f == 1) ? a - b : a * b;
        ov = (t > MAXV) || (t < MINV);
`ifdef SATURATE_EN
        o = !ov ? t : (t > 0) ? MAXV : MINV;
`else
        o = wrap(t);
`endif
      end
      3: o = (a == 0) ? TV : 0;
      4: o = (a < b) ? TV : 0;
      5: o = (a > b) ? TV : 0;
      default: ill = 1'b1;
    endcase
  endtask

  // One full transaction: offer, wait for result, hold for 'hold' cycles, consume.
  task automatic do_op(input longint a, input longint b, input int f, input int hold,
                       output longint o, output bit ov, output bit ill,
                       output bit gr, output bit le, output bit eq, output int lat);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in0 = W'(a); in1 = W'(b); funct = 4'(f); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk("in_ready_busy", longint'(in_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("in_ready_done", longint'(in_ready), 0);
    o = longint'(out); ov = overflow; ill = illegal;
    gr = gr_flag; le = le_flag; eq = eq_flag;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out", longint'(out), o);
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_status", longint'({overflow, illegal, gr_flag, le_flag, eq_flag}),
          longint'({ov, ill, gr, le, eq}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_in_ready", longint'(in_ready), 1);
    chk("consume_valid", longint'(out_valid), 0);
  endtask

  typedef struct {
    longint a; longint b; int f;
    longint e_out; bit e_ov; bit e_ill; bit e_gr; bit e_le; bit e_eq; int e_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    longint o, mo;
    bit ov, ill, gr, le, eq, mov, mill;
    int lat;
    longint a, b;
    int f, r;

`ifdef SATURATE_EN
    vecs[0]  = '{1000, 100, 0, 1023, 1, 0, 1, 0, 0, 1};
    vecs[2]  = '{-50, 30, 2, -1024, 1, 0, 0, 1, 0, 12};
    vecs[3]  = '{-1024, -1, 2, 1023, 1, 0, 0, 1, 0, 12};
    vecs[11] = '{-1000, 100, 1, -1024, 1, 0, 0, 1, 0, 1};
`else
    vecs[0]  = '{1000, 100, 0, -948, 1, 0, 1, 0, 0, 1};
    vecs[2]  = '{-50, 30, 2, 548, 1, 0, 0, 1, 0, 12};
    vecs[3]  = '{-1024, -1, 2, -1024, 1, 0, 0, 1, 0, 12};
    vecs[11] = '{-1000, 100, 1, 948, 1, 0, 0, 1, 0, 1};
`endif
    vecs[1]  = '{31, -33, 2, -1023, 0, 0, 1, 0, 0, 12};
    vecs[4]  = '{-1024, 1, 2, -1024, 0, 0, 0, 1, 0, 12};
    vecs[5]  = '{0, 0, 3, 127, 0, 0, 0, 0, 1, 1};
    vecs[6]  = '{5, 0, 3, 0, 0, 0, 1, 0, 0, 1};
    vecs[7]  = '{-3, -3, 4, 0, 0, 0, 0, 0, 1, 1};
    vecs[8]  = '{4, -4, 5, 127, 0, 0, 1, 0, 0, 1};
    vecs[9]  = '{7, 2, 9, 0, 0, 1, 1, 0, 0, 1};
    vecs[10] = '{3, 5, 1, -2, 0, 0, 0, 1, 0, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in0 = '0; in1 = '0; funct = '0;
    #12;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out", longint'(out), 0);
    chk("rst_status", longint'({overflow, illegal, gr_flag, le_flag, eq_flag}), 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed table; vector 10 follows the illegal op and must clear illegal.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].f, 0, o, ov, ill, gr, le, eq, lat);
      chk($sformatf("v%0d_out", i), o, vecs[i].e_out);
      chk($sformatf("v%0d_ovf", i), longint'(ov), longint'(vecs[i].e_ov));
      chk($sformatf("v%0d_illegal", i), longint'(ill), longint'(vecs[i].e_ill));
      chk($sformatf("v%0d_flags", i), longint'({gr, le, eq}),
          longint'({vecs[i].e_gr, vecs[i].e_le, vecs[i].e_eq}));
      chk($sformatf("v%0d_latency", i), longint'(lat), longint'(vecs[i].e_lat));
    end

    // Backpressure: SUB result held for 5 cycles.
    do_op(100, 250, 1, 5, o, ov, ill, gr, le, eq, lat);
    chk("bp_out", o, -150);
    chk("bp_flags", longint'({gr, le, eq}), longint'(3'b010));

    // Reset during MUL cycle 5 aborts with everything cleared asynchronously.
    @(negedge clk);
    in0 = 11'sd31; in1 = -11'sd33; funct = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_out", longint'(out), 0);
    chk("abort_status", longint'({overflow, illegal, gr_flag, le_flag, eq_flag}), 0);
    @(negedge clk); rst_n = 1'b1;
    do_op(2, 3, 0, 0, o, ov, ill, gr, le, eq, lat);
    chk("post_abort_out", o, 5);
    chk("post_abort_latency", longint'(lat), 1);

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      a = longint'($urandom_range(0, 2047)) - 1024;
      b = ($urandom_range(0, 7) == 0) ? a : longint'($urandom_range(0, 2047)) - 1024;
      if ($urandom_range(0, 9) == 0) a = 0;
      r = int'($urandom_range(0, 6));
      f = (r == 6) ? int'($urandom_range(6, 15)) : r;
      do_op(a, b, f, int'($urandom_range(0, 2)), o, ov, ill, gr, le, eq, lat);
      model(a, b, f, mo, mov, mill);
      chk($sformatf("rnd%0d_out f=%0d a=%0d b=%0d", n, f, a, b), o, mo);
      chk($sformatf("rnd%0d_ovf", n), longint'(ov), longint'(mov));
      chk($sformatf("rnd%0d_illegal", n), longint'(ill), longint'(mill));
      chk($sformatf("rnd%0d_flags", n), longint'({gr, le, eq}),
          longint'({a > b, a < b, a == b}));
      chk($sformatf("rnd%0d_latency", n), longint'(lat), (f == 2) ? longint'(W + 1) : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
